conv_window_sequencer: RTL

Parametrised successor to the convolution checker datapath. Tracks a circular IF scratchpad (write pointer, fill count), sequences sliding-window read addresses over IF and a multi-filter filter scratchpad, and emits multiply strobes, per-filter partial-sum-done pulses and a done flag. Sits between the scratchpad writers and the MAC datapath. Adds stride-based window release, multiple filters, backpressure and configuration error detection.

---
 rtl/conv_window_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_sequencer
// Brief    : Circular IF scratchpad tracker and sliding-window address
//            sequencer for a multi-filter MAC datapath. Issues one multiply
//            beat per accepted cycle (window -> filter -> tap), flags the
//            last tap of each filter, and releases IF slots by stride.
//            A stride larger than filter_size would release slots that were
//            never buffered, so writers keep stride <= filter_size.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_sequencer #(
    parameter int IF_ADDRESS_SIZE     = 4,
    parameter int FILTER_ADDRESS_SIZE = 5,
    parameter int STRIDE_SIZE         = 2,
    parameter int SIZE_W              = 4,
    parameter int LEN_W               = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [STRIDE_SIZE-1:0]         stride,
    input  logic [SIZE_W-1:0]              filter_size,
    input  logic [SIZE_W-1:0]              filter_count,
    input  logic [LEN_W-1:0]               if_len,
    input  logic                           write_req,
    output logic                           scratch_write_en,
    output logic [IF_ADDRESS_SIZE-1:0]     write_addr_if,
    output logic                           if_full,
    output logic [IF_ADDRESS_SIZE-1:0]     read_addr_if,
    output logic [FILTER_ADDRESS_SIZE-1:0] read_addr_filter,
    output logic                           mult_valid,
    input  logic                           mult_ready,
    output logic                           par_done,
    output logic [SIZE_W-1:0]              par_filter,
    output logic                           cfg_err,
    output logic                           done
);

    localparam int C_DEPTH      = 1 << IF_ADDRESS_SIZE;
    localparam int C_FILL_W     = IF_ADDRESS_SIZE + 1;
    localparam int C_FADDR_SPAN = 1 << FILTER_ADDRESS_SIZE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         r_state;
    logic [IF_ADDRESS_SIZE-1:0]     r_wptr;
    logic [C_FILL_W-1:0]            r_fill;
    logic [IF_ADDRESS_SIZE-1:0]     r_start_if;
    logic [SIZE_W-1:0]              r_k;
    logic [SIZE_W-1:0]              r_f;
    logic [FILTER_ADDRESS_SIZE-1:0] r_base;
    // Window counter kept as the absolute IF offset of the current window,
    // so the final-window test needs no divider.
    logic [LEN_W:0]                 r_win_pos;
    logic [STRIDE_SIZE-1:0]         r_stride;
    logic [SIZE_W-1:0]              r_fsize;
    logic [SIZE_W-1:0]              r_fcount;
    logic [LEN_W-1:0]               r_len;
    logic                           r_mult_valid;
    logic                           r_cfg_err;
    logic                           r_done;

    logic                           w_full;
    logic                           w_wen;
    logic                           w_beat;
    logic                           w_last_tap;
    logic                           w_last_filt;
    logic                           w_release;
    logic                           w_final_win;
    logic                           w_refill_ok;
    logic                           w_cfg_bad;
    logic [C_FILL_W-1:0]            w_fill_next;

    assign w_full      = (r_fill == C_FILL_W'(C_DEPTH));
    assign w_wen       = write_req & ~w_full;
    assign w_beat      = (r_state == S_RUN) & mult_ready;
    assign w_last_tap  = (r_k == r_fsize - SIZE_W'(1));
    assign w_last_filt = (r_f == r_fcount - SIZE_W'(1));
    assign w_release   = w_beat & w_last_tap & w_last_filt;
    // The window just finished is the last one when the next would overrun.
    assign w_final_win = (32'(r_win_pos) + 32'(r_stride) + 32'(r_fsize)) > 32'(r_len);
    assign w_refill_ok = 32'(r_fill) >= (32'(r_stride) + 32'(r_fsize));
    assign w_fill_next = r_fill + C_FILL_W'(w_wen)
                       - (w_release ? C_FILL_W'(r_stride) : '0);

    assign w_cfg_bad = (stride == '0) || (filter_size == '0) || (filter_count == '0)
                    || (32'(filter_size) > 32'(if_len))
                    || (32'(filter_size) > 32'(C_DEPTH))
                    || ((32'(filter_count) * 32'(filter_size)) > 32'(C_FADDR_SPAN));

    assign scratch_write_en = w_wen;
    assign write_addr_if    = r_wptr;
    assign if_full          = w_full;
    assign read_addr_if     = r_start_if + IF_ADDRESS_SIZE'(r_k);
    assign read_addr_filter = r_base + FILTER_ADDRESS_SIZE'(r_k);
    assign mult_valid       = r_mult_valid;
    assign par_done         = r_mult_valid & mult_ready & w_last_tap;
    assign par_filter       = r_f;
    assign cfg_err          = r_cfg_err;
    assign done             = r_done;

    // Scratchpad bookkeeping plus the window/filter/tap sequencing FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_fill       <= '0;
            r_start_if   <= '0;
            r_k          <= '0;
            r_f          <= '0;
            r_base       <= '0;
            r_win_pos    <= '0;
            r_stride     <= '0;
            r_fsize      <= '0;
            r_fcount     <= '0;
            r_len        <= '0;
            r_mult_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Final release discards trailing data, including a same-cycle write.
            if (w_release && w_final_win) begin
                r_fill <= '0;
                r_wptr <= '0;
            end else begin
                r_fill <= w_fill_next;
                if (w_wen) begin
                    r_wptr <= r_wptr + IF_ADDRESS_SIZE'(1);
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_stride     <= stride;
                        r_fsize      <= filter_size;
                        r_fcount     <= filter_count;
                        r_len        <= if_len;
                        r_start_if   <= '0;
                        r_k          <= '0;
                        r_f          <= '0;
                        r_base       <= '0;
                        r_win_pos    <= '0;
                        r_mult_valid <= 1'b0;
                        r_cfg_err    <= w_cfg_bad;
                        r_done       <= w_cfg_bad;
                        r_state      <= w_cfg_bad ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (32'(r_fill) >= 32'(r_fsize)) begin
                        r_state      <= S_RUN;
                        r_mult_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        if (!w_last_tap) begin
                            r_k <= r_k + SIZE_W'(1);
                        end else begin
                            r_k <= '0;
                            if (!w_last_filt) begin
                                r_f    <= r_f + SIZE_W'(1);
                                r_base <= r_base + FILTER_ADDRESS_SIZE'(r_fsize);
                            end else begin
                                r_f        <= '0;
                                r_base     <= '0;
                                r_win_pos  <= r_win_pos + (LEN_W+1)'(r_stride);
                                r_start_if <= r_start_if + IF_ADDRESS_SIZE'(r_stride);
                                if (w_final_win) begin
                                    r_state      <= S_DONE;
                                    r_done       <= 1'b1;
                                    r_mult_valid <= 1'b0;
                                end else if (!w_refill_ok) begin
                                    r_state      <= S_WAIT;
                                    r_mult_valid <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
